// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the MIPS HI/LO pair.
// MULT/MULTU/DIV/DIVU take WIDTH+2 cycles; MTHI/MTLO complete in one.
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               bz_q, bz_d;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign2(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign signed_op = op[0];
  assign mag_a     = magnitude(A, signed_op);
  assign mag_b     = magnitude(B, signed_op);

  // Multiply: upper half accumulates the multiplicand, multiplier shifts out of the low half.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opnd_q};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: upper half is the partial remainder, low half shifts dividend out and quotient in.
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = {div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0],
                     acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  assign prod_s = apply_sign2(acc_q, negq_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    bz_d     = bz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          if (!op[2]) begin
            is_div_d = op[1];
            negq_d   = signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
            negr_d   = signed_op & A[WIDTH-1];
            bz_d     = (B == '0);
            opnd_d   = op[1] ? mag_b : mag_a;
            acc_d    = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
            cnt_d    = '0;
            state_d  = CALC;
          end else begin
            done_d = 1'b1;
            if (op[1:0] == 2'b00) hi_d = A;
            else if (op[1:0] == 2'b01) lo_d = A;
          end
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
      end
      FIXUP: begin
        if (is_div_q) begin
          lo_d  = bz_q ? '1 : apply_sign(acc_q[WIDTH-1:0], negq_q);
          hi_d  = apply_sign(acc_q[2*WIDTH-1:WIDTH], negr_q);
          dbz_d = bz_q;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_ff @(posedge CLK) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    negq_q   <= negq_d;
    negr_q   <= negr_d;
    bz_q     <= bz_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit that sits beside the MIPS ALU in the datapath and owns the HI/LO register pair.
- Executes MULT, MULTU, DIV, DIVU as radix-2 multi-cycle operations, and MTHI/MTLO as single-cycle writes.
- Uses a start/busy/done handshake so the controller can stall on MFHI/MFLO while an operation is running.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
CLK  input  1  clock; all state changes on posedge
RESET  input  1  asynchronous, active-low reset
start  input  1  request; sampled on posedge, accepted only when busy=0
op  input  3  0=MULTU 1=MULT 2=DIVU 3=DIV 4=MTHI 5=MTLO; 6,7 reserved (accepted as no-op)
A  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
B  input  WIDTH  rt operand (multiplier/divisor)
busy  output  1  high while a mul/div is in flight
done  output  1  one-cycle pulse; HI/LO hold the new result in the same cycle
HI  output  WIDTH  mult: upper product; div: remainder
LO  output  WIDTH  mult: lower product; div: quotient
div_by_zero  output  1  set with done for DIV/DIVU with B=0; cleared on the next accepted start

Behaviour:
- RESET low: immediately, regardless of CLK, state=IDLE, HI=0, LO=0, busy=0, done=0, div_by_zero=0, counter=0. Asserting reset mid-operation aborts the operation; the partial result is discarded.
- FSM states are IDLE, CALC, FIXUP. busy = (state != IDLE).
- IDLE with start=1 and op in 0..3, at edge E0:
  - Latch the magnitudes of A and B. For signed ops use two's-complement absolute value; for unsigned ops latch as-is.
  - Latch neg_q = sA^sB and neg_r = sA for signed ops (0 for unsigned).
  - Clear the counter and div_by_zero; go to CALC.
- CALC: one iteration per edge, counter increments. After exactly WIDTH iterations (edges E1..E_WIDTH) go to FIXUP.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per edge.
- FIXUP, at edge E_WIDTH+1:
  - Apply signs: product negated if neg_q; quotient negated if neg_q; remainder negated if neg_r.
  - Write HI/LO, set done=1, go to IDLE.
  - Net latency: done is high in the cycle after edge WIDTH+1 (34 cycles for WIDTH=32); busy is low in that cycle.
- done is cleared on the next edge unless a new completion occurs.
- start in the done cycle is accepted (state is IDLE). Back-to-back operations are allowed.
- start while busy=1 is ignored: operands, op and state are unaffected, and no error is raised.
- MTHI/MTLO (op 4/5) accepted in IDLE: at E0, HI<=A (or LO<=A), the other register is unchanged, done=1 next cycle, busy stays 0.
- op 6/7 accepted in IDLE: HI/LO unchanged, done=1 next cycle.
- Divide by zero (B=0, op 2/3):
  - Full WIDTH+2 latency is kept.
  - Result is HI=A (original signed value), LO=all ones, div_by_zero=1 with done.
  - div_by_zero holds until the next accepted start.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): LO=-2^(WIDTH-1) (wraps), HI=0, no flag.
- Signed divide truncates toward zero; the remainder takes the sign of the dividend.
- HI/LO change only at FIXUP, at MTHI/MTLO, or on reset. They are stable and readable at all other times, including while busy.
- All arithmetic is done internally at WIDTH+1 / 2*WIDTH bits; outputs are truncated to WIDTH.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done exactly 34 cycles after the start edge; HI=0xFFFFFFFE, LO=0x00000001; busy high for 33 cycles.
- MULT A=0xFFFFFFFD(-3) B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1 (-15); then DIV A=0xFFFFFFF9(-7) B=2 issued in the done cycle -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU A=0x64 B=0 -> after 34 cycles HI=0x64, LO=0xFFFFFFFF, div_by_zero=1; next MTLO A=0x5 -> div_by_zero=0, LO=0x5, HI=0x64, done one cycle later.
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0x0, div_by_zero=0.
- MULTU 7*6 started, start pulsed with op=MTHI A=0x1234 at cycle 10 -> ignored; final HI=0, LO=0x2A. Repeat with RESET low at cycle 15 -> busy=0, HI=LO=0 asynchronously, no done pulse.
- WIDTH=8 instance: DIVU A=0xC8 B=0x07 -> LO=0x1C, HI=0x04, done 10 cycles after start.
